// File: rtl/spw_pkg.sv
// Shared definitions for the SpaceWire-style packet crossbar.
// Holds the per-input FSM state encoding, the default port count and
// the helper that sizes port-index fields.
package spw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a path-address header
    ST_REQ  = 2'd1,  // header accepted, requesting the target output
    ST_FWD  = 2'd2,  // granted, characters pass straight through
    ST_DROP = 2'd3   // bad address, swallow characters until EOP
  } spw_state_e;

  localparam int SPW_PORTS_DEF = 8;

  // Index width for n ports; never narrower than one bit.
  function automatic int spw_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SPW_IDX_W = spw_idx_w(SPW_PORTS_DEF);

endpackage

// File: rtl/spw_rr_arbiter.sv
// Per-output round-robin arbiter with a registered grant.
//   clk, rst   : clock, async active-high reset
//   req_i      : one bit per input currently requesting this output
//   release_i  : EOP handshake seen on this output this cycle
//   gnt_o      : one-hot grant decision taken this cycle (takes effect next)
//   busy_o     : output currently owned by an input
//   owner_o    : index of the owning input
module spw_rr_arbiter
  import spw_pkg::*;
#(
  parameter int PORTS = SPW_PORTS_DEF,
  parameter int IW    = SPW_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req_i,
  input  logic             release_i,
  output logic [PORTS-1:0] gnt_o,
  output logic             busy_o,
  output logic [IW-1:0]    owner_o
);

  logic          busy_q;
  logic [IW-1:0] owner_q, ptr_q;
  logic [IW-1:0] win, ptr_nxt, idx;
  logic          found;

  // Reduce a value in [0, 2*PORTS) modulo PORTS.
  function automatic logic [IW-1:0] wrap(input logic [IW:0] v);
    return (v >= (IW+1)'(PORTS)) ? IW'(v - (IW+1)'(PORTS)) : v[IW-1:0];
  endfunction

  // Search starts at the pointer (last winner + 1). A busy output does not
  // arbitrate, and busy_q only drops after the EOP edge, so a freed output
  // is first re-granted one cycle later.
  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    ptr_nxt = ptr_q;
    if (!busy_q) begin
      for (int k = 0; k < PORTS; k++) begin
        idx = wrap({1'b0, ptr_q} + (IW+1)'(k));
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          win        = idx;
          gnt_o[idx] = 1'b1;
          ptr_nxt    = wrap({1'b0, idx} + (IW+1)'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (busy_q && release_i) begin
      busy_q <= 1'b0;
    end else if (found) begin
      busy_q  <= 1'b1;
      owner_q <= win;
      ptr_q   <= ptr_nxt;
    end
  end

  assign busy_o  = busy_q;
  assign owner_o = owner_q;

endmodule

// File: rtl/spw_crossbar.sv
// Packet-switched crossbar: the first character of each packet selects the
// output, is stripped, and the rest of the packet is cut through with zero
// latency once that output is granted. Bad addresses are discarded and
// counted.
//   clk, rst            : clock, async active-high reset
//   rx_data/eop/valid   : per-input character stream, rx_ready back-pressure
//   tx_data/eop/valid   : per-output character stream, tx_ready back-pressure
//   out_busy            : output currently granted
//   drop_count          : saturating count of discarded packets
module spw_crossbar
  import spw_pkg::*;
#(
  parameter int PORTS  = SPW_PORTS_DEF,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS*DATA_W-1:0] rx_data,
  input  logic [PORTS-1:0]        rx_eop,
  input  logic [PORTS-1:0]        rx_valid,
  output logic [PORTS-1:0]        rx_ready,
  output logic [PORTS*DATA_W-1:0] tx_data,
  output logic [PORTS-1:0]        tx_eop,
  output logic [PORTS-1:0]        tx_valid,
  input  logic [PORTS-1:0]        tx_ready,
  output logic [PORTS-1:0]        out_busy,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int IW = spw_idx_w(PORTS);
  localparam int NW = $clog2(PORTS + 1);

  logic [PORTS-1:0][DATA_W-1:0] rxd, txd;
  spw_state_e                   st_q [PORTS];
  logic [PORTS-1:0][IW-1:0]     tgt_q;
  logic [PORTS-1:0]             req  [PORTS];  // [output][input]
  logic [PORTS-1:0]             gnt  [PORTS];  // [output][input]
  logic [IW-1:0]                owner[PORTS];
  logic [PORTS-1:0]             busy, rel, gnt_in, hdr_ok, drop_ev;
  logic [NW-1:0]                ndrop;
  logic [CNT_W+NW-1:0]          sum;
  logic [CNT_W-1:0]             drop_q, drop_d;

  assign rxd        = rx_data;
  assign tx_data    = txd;
  assign out_busy   = busy;
  assign drop_count = drop_q;

  // Request fan-out and grant fan-in.
  always_comb begin
    gnt_in = '0;
    for (int o = 0; o < PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < PORTS; i++) begin
        req[o][i] = (st_q[i] == ST_REQ) && (tgt_q[i] == IW'(o));
        gnt_in[i] = gnt_in[i] | gnt[o][i];
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_arb
    spw_rr_arbiter #(.PORTS(PORTS), .IW(IW)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req[o]),
      .release_i (rel[o]),
      .gnt_o     (gnt[o]),
      .busy_o    (busy[o]),
      .owner_o   (owner[o])
    );
  end

  // Output mux: granted outputs mirror their owner, others are held at zero.
  always_comb begin
    txd      = '0;
    tx_eop   = '0;
    tx_valid = '0;
    rel      = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (busy[o]) begin
        txd[o]      = rxd[owner[o]];
        tx_eop[o]   = rx_eop[owner[o]];
        tx_valid[o] = rx_valid[owner[o]];
      end
      rel[o] = busy[o] & tx_valid[o] & tx_ready[o] & tx_eop[o];
    end
  end

  // Input side back-pressure and drop detection.
  always_comb begin
    rx_ready = '0;
    hdr_ok   = '0;
    drop_ev  = '0;
    for (int i = 0; i < PORTS; i++) begin
      hdr_ok[i] = rxd[i] < DATA_W'(PORTS);
      case (st_q[i])
        ST_IDLE, ST_DROP: rx_ready[i] = 1'b1;
        ST_FWD:           rx_ready[i] = tx_ready[tgt_q[i]];
        default:          rx_ready[i] = 1'b0;
      endcase
      // A header carrying EOP, or the EOP of a dropped packet.
      drop_ev[i] = rx_valid[i] & rx_eop[i] &
                   ((st_q[i] == ST_IDLE) | (st_q[i] == ST_DROP));
    end
  end

  // Simultaneous drops are summed, then clamped at all-ones.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < PORTS; i++) ndrop = ndrop + NW'(drop_ev[i]);
    sum    = {{NW{1'b0}}, drop_q} + {{CNT_W{1'b0}}, ndrop};
    drop_d = (sum > {{NW{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORTS; i++) st_q[i] <= ST_IDLE;
      tgt_q  <= '0;
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
      for (int i = 0; i < PORTS; i++) begin
        case (st_q[i])
          ST_IDLE:
            if (rx_valid[i] && !rx_eop[i]) begin
              if (hdr_ok[i]) begin
                st_q[i]  <= ST_REQ;
                tgt_q[i] <= rxd[i][IW-1:0];
              end else begin
                st_q[i] <= ST_DROP;
              end
            end
          ST_REQ:
            if (gnt_in[i]) st_q[i] <= ST_FWD;
          ST_FWD:
            if (rx_valid[i] && rx_ready[i] && rx_eop[i]) st_q[i] <= ST_IDLE;
          ST_DROP:
            if (rx_valid[i] && rx_eop[i]) st_q[i] <= ST_IDLE;
          default:
            st_q[i] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spw_crossbar.sv
module tb_spw_crossbar;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rx_data;
  logic [7:0]  rx_eop, rx_valid, rx_ready;
  logic [63:0] tx_data;
  logic [7:0]  tx_eop, tx_valid, tx_ready, out_busy;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  spw_crossbar #(.PORTS(8), .DATA_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_eop     (rx_eop),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_eop     (tx_eop),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .out_busy   (out_busy),
    .drop_count (drop_count)
  );

  // Record every character that completes a handshake on output 3.
  always @(negedge clk)
    if (!rst && tx_valid[3] && tx_ready[3]) q3.push_back(tx_data[31:24]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i, input logic v, input logic [7:0] d, input logic e);
    rx_valid[i]      = v;
    rx_data[i*8 +: 8] = d;
    rx_eop[i]        = e;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_eop = '0; rx_valid = '0; tx_ready = '1;
    #2;
    chk("rst_busy", out_busy, 8'h00);
    chk("rst_txv", tx_valid, 8'h00);
    chk("rst_drop", drop_count, 16'h0);
    chk("rst_rdy", rx_ready, 8'hFF);
    cyc(); cyc(); rst = 1'b0;

    // Input 0 -> output 3, header stripped, grant two cycles after header.
    cyc(); drv(0, 1, 8'h03, 0); #1;
    chk("A_hdr_rdy", rx_ready[0], 1'b1);
    chk("A_hdr_txv", tx_valid, 8'h00);
    cyc(); drv(0, 1, 8'hA5, 0); #1;
    chk("A_req_rdy", rx_ready[0], 1'b0);
    chk("A_req_busy", out_busy, 8'h00);
    cyc(); #1;
    chk("A_gnt_busy", out_busy, 8'h08);
    chk("A_gnt_data", tx_data, 64'h00000000_A5000000);
    chk("A_gnt_eop", tx_eop, 8'h00);
    chk("A_gnt_rdy", rx_ready[0], 1'b1);
    cyc(); drv(0, 1, 8'h5A, 1); #1;
    chk("A_eop_data", tx_data, 64'h00000000_5A000000);
    chk("A_eop_flag", tx_eop, 8'h08);
    cyc(); drv(0, 0, 8'h00, 0); #1;
    chk("A_free_busy", out_busy, 8'h00);
    chk("A_free_txv", tx_valid, 8'h00);
    chk("A_free_data", tx_data, 64'h0);

    // Inputs 1 and 2 contend for output 5 with pointer 0.
    cyc(); drv(1, 1, 8'h05, 0); drv(2, 1, 8'h05, 0); #1;
    cyc(); drv(1, 1, 8'h11, 0); drv(2, 1, 8'h22, 0); #1;
    chk("B_req_rdy", rx_ready[2:1], 2'b00);
    cyc(); #1;
    chk("B_g1_busy", out_busy, 8'h20);
    chk("B_g1_data", tx_data[47:40], 8'h11);
    chk("B_g1_rdy", rx_ready[2:1], 2'b01);
    cyc(); drv(1, 1, 8'h12, 1); #1;
    chk("B_e1_data", tx_data[47:40], 8'h12);
    chk("B_e1_eop", tx_eop, 8'h20);
    cyc(); drv(1, 0, 8'h00, 0); #1;
    chk("B_gap_busy", out_busy, 8'h00);
    chk("B_gap_rdy2", rx_ready[2], 1'b0);
    cyc(); #1;
    chk("B_g2_busy", out_busy, 8'h20);
    chk("B_g2_data", tx_data[47:40], 8'h22);
    chk("B_g2_rdy", rx_ready[2:1], 2'b11);
    cyc(); drv(2, 1, 8'h23, 1); #1;
    chk("B_e2_data", tx_data[47:40], 8'h23);
    cyc(); drv(2, 0, 8'h00, 0); #1;

    // Pointer now 3: inputs 1 and 3 contend, input 3 must win.
    cyc(); drv(1, 1, 8'h05, 0); drv(3, 1, 8'h05, 0); #1;
    cyc(); drv(1, 1, 8'h31, 1); drv(3, 1, 8'h33, 1); #1;
    cyc(); #1;
    chk("B3_win_data", tx_data[47:40], 8'h33);
    chk("B3_win_rdy", rx_ready[3:1], 3'b110);
    chk("B3_win_eop", tx_eop, 8'h20);
    cyc(); drv(3, 0, 8'h00, 0); #1;
    chk("B3_gap_busy", out_busy, 8'h00);
    cyc(); #1;
    chk("B3_next_data", tx_data[47:40], 8'h31);
    cyc(); drv(1, 0, 8'h00, 0); #1;
    chk("B3_end_busy", out_busy, 8'h00);

    // Bad header 0x09: whole packet swallowed, ready held high.
    cyc();
    for (int k = 0; k < 6; k++) begin
      drv(4, 1, (k == 0) ? 8'h09 : 8'(8'h40 + k), k == 5); #1;
      chk("C_drop_rdy", rx_ready[4], 1'b1);
      chk("C_drop_txv", tx_valid, 8'h00);
      cyc();
    end
    drv(4, 0, 8'h00, 0); #1;
    chk("C_cnt1", drop_count, 16'd1);
    // Two header+EOP packets in the same cycle add two.
    cyc(); drv(6, 1, 8'h02, 1); drv(7, 1, 8'h0B, 1); #1;
    chk("C_dual_rdy", rx_ready, 8'hFF);
    cyc(); drv(6, 0, 8'h00, 0); drv(7, 0, 8'h00, 0); #1;
    chk("C_cnt3", drop_count, 16'd3);
    chk("C_idle_busy", out_busy, 8'h00);

    // Back-pressure on output 3 for 10 cycles mid-packet.
    q3.delete();
    cyc(); drv(0, 1, 8'h03, 0); #1;
    cyc(); drv(0, 1, 8'hB0, 0); #1;
    cyc(); #1;
    chk("D_gnt_data", tx_data[31:24], 8'hB0);
    cyc(); drv(0, 1, 8'hB1, 0); tx_ready[3] = 1'b0; #1;
    for (int k = 0; k < 10; k++) begin
      chk("D_stall_rdy", rx_ready[0], 1'b0);
      chk("D_stall_txv", tx_valid[3], 1'b1);
      chk("D_stall_data", tx_data[31:24], 8'hB1);
      cyc(); #1;
    end
    tx_ready[3] = 1'b1; #1;
    chk("D_resume_rdy", rx_ready[0], 1'b1);
    cyc(); drv(0, 1, 8'hB2, 1); #1;
    chk("D_eop_data", tx_data[31:24], 8'hB2);
    cyc(); drv(0, 0, 8'h00, 0); #1;
    chk("D_q_len", 64'(q3.size()), 64'd3);
    chk("D_q0", q3[0], 8'hB0);
    chk("D_q1", q3[1], 8'hB1);
    chk("D_q2", q3[2], 8'hB2);

    // Reset in the middle of a forwarded packet.
    cyc(); drv(2, 1, 8'h06, 0); #1;
    cyc(); drv(2, 1, 8'hC0, 0); #1;
    cyc(); #1;
    chk("E_gnt_busy", out_busy, 8'h40);
    cyc(); drv(2, 1, 8'hC1, 0); #1;
    rst = 1'b1; #1;
    chk("E_rst_txv", tx_valid, 8'h00);
    chk("E_rst_busy", out_busy, 8'h00);
    chk("E_rst_rdy", rx_ready, 8'hFF);
    chk("E_rst_drop", drop_count, 16'h0);
    drv(2, 0, 8'h00, 0);
    cyc(); cyc(); rst = 1'b0;
    // Fresh packet after reset, looped back from input 6 to output 6.
    cyc(); drv(6, 1, 8'h06, 0); #1;
    cyc(); drv(6, 1, 8'hD0, 1); #1;
    cyc(); #1;
    chk("E_lb_busy", out_busy, 8'h40);
    chk("E_lb_data", tx_data, 64'h00D00000_00000000);
    chk("E_lb_eop", tx_eop, 8'h40);
    cyc(); drv(6, 0, 8'h00, 0); #1;
    chk("E_end_busy", out_busy, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
